// File: rtl/keypad_matrix_emulator.sv
// Emulated 4x4 active-low key matrix: one commanded key closes with contact bounce on press and
// release, answers the scanner's column drive on row, then holds the contact open for a gap.
module keypad_matrix_emulator #(
    parameter int BOUNCE_TOGGLES = 4,
    parameter int BOUNCE_PERIOD  = 2,
    parameter int GAP_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] shift_col,
    input  logic       key_req_valid,
    input  logic [3:0] key_req_idx,
    input  logic [7:0] key_req_hold,
    output logic       key_req_ready,
    input  logic       abort,
    output logic [3:0] row,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       contact,
    output logic [2:0] state_dbg
);
    // Request handshake: a request transfers on the rising edge where key_req_valid and
    // key_req_ready are both high; ready is high exactly while the emulator sits in IDLE.

    localparam int CNT_W  = (GAP_CYCLES > 256) ? $clog2(GAP_CYCLES) : 8;
    localparam int SUB_W  = (BOUNCE_PERIOD > 1) ? $clog2(BOUNCE_PERIOD) : 1;
    localparam int STEP_W = (BOUNCE_TOGGLES > 1) ? $clog2(BOUNCE_TOGGLES) : 1;

    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(BOUNCE_PERIOD - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(BOUNCE_TOGGLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRESS = 3'd1,
        S_HOLD  = 3'd2,
        S_REL   = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            state_q;
    logic              contact_q;
    logic              done_q;
    logic              aborted_q;
    logic [3:0]        idx_q;
    logic [7:0]        hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SUB_W-1:0]  sub_q;
    logic [STEP_W-1:0] step_q;
    logic [7:0]        hold_eff;
    logic              active;

    assign hold_eff = (key_req_hold == 8'd0) ? 8'd1 : key_req_hold;
    assign active   = (state_q == S_PRESS) || (state_q == S_HOLD) || (state_q == S_REL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            idx_q     <= 4'd0;
            hold_q    <= 8'd1;
            cnt_q     <= '0;
            sub_q     <= '0;
            step_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort && active) begin
                // Abort beats any phase exit landing on the same edge.
                state_q   <= S_GAP;
                contact_q <= 1'b0;
                aborted_q <= 1'b1;
                cnt_q     <= GAP_LOAD;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (key_req_valid) begin
                            idx_q     <= key_req_idx;
                            hold_q    <= hold_eff;
                            aborted_q <= 1'b0;
                            contact_q <= 1'b1;
                            sub_q     <= '0;
                            step_q    <= '0;
                            if (BOUNCE_TOGGLES == 0) begin
                                state_q <= S_HOLD;
                                cnt_q   <= CNT_W'(hold_eff) - CNT_W'(1);
                            end else begin
                                state_q <= S_PRESS;
                            end
                        end
                    end
                    S_PRESS: begin
                        if (sub_q == SUB_LAST) begin
                            sub_q <= '0;
                            if (step_q == STEP_LAST) begin
                                state_q   <= S_HOLD;
                                contact_q <= 1'b1;
                                cnt_q     <= CNT_W'(hold_q) - CNT_W'(1);
                            end else begin
                                step_q    <= step_q + STEP_W'(1);
                                contact_q <= step_q[0];
                            end
                        end else begin
                            sub_q <= sub_q + SUB_W'(1);
                        end
                    end
                    S_HOLD: begin
                        if (cnt_q == '0) begin
                            contact_q <= 1'b0;
                            if (BOUNCE_TOGGLES == 0) begin
                                state_q <= S_GAP;
                                cnt_q   <= GAP_LOAD;
                            end else begin
                                state_q <= S_REL;
                                sub_q   <= '0;
                                step_q  <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    S_REL: begin
                        if (sub_q == SUB_LAST) begin
                            sub_q <= '0;
                            if (step_q == STEP_LAST) begin
                                state_q   <= S_GAP;
                                contact_q <= 1'b0;
                                cnt_q     <= GAP_LOAD;
                            end else begin
                                step_q    <= step_q + STEP_W'(1);
                                contact_q <= ~step_q[0];
                            end
                        end else begin
                            sub_q <= sub_q + SUB_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (cnt_q == '0) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        contact_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        row = 4'b1111;
        if (contact_q && !shift_col[idx_q[3:2]]) begin
            row[idx_q[1:0]] = 1'b0;
        end
    end

    assign key_req_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign contact       = contact_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: a schedule-based model checks every cycle of the default
// instance; a second instance without bounce is checked against hand-computed values.
module tb_keypad_matrix_emulator;
    localparam int BT  = 4;
    localparam int BP  = 2;
    localparam int GAP = 8;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_ACT  = 2'd1;
    localparam logic [1:0] PH_GAP  = 2'd2;
    localparam logic [1:0] PH_DONE = 2'd3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic [3:0] shift_col;
    logic       key_req_valid;
    logic [3:0] key_req_idx;
    logic [7:0] key_req_hold;
    logic       key_req_ready;
    logic       abort;
    logic [3:0] row;
    logic       busy, done, aborted, contact;
    logic [2:0] state_dbg;

    logic [3:0] b_shift_col;
    logic       b_valid;
    logic [3:0] b_idx;
    logic [7:0] b_hold;
    logic       b_ready;
    logic       b_abort;
    logic [3:0] b_row;
    logic       b_busy, b_done, b_aborted, b_contact;
    logic [2:0] b_state;

    keypad_matrix_emulator #(.BOUNCE_TOGGLES(BT), .BOUNCE_PERIOD(BP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .shift_col(shift_col), .key_req_valid(key_req_valid),
        .key_req_idx(key_req_idx), .key_req_hold(key_req_hold), .key_req_ready(key_req_ready),
        .abort(abort), .row(row), .busy(busy), .done(done), .aborted(aborted),
        .contact(contact), .state_dbg(state_dbg)
    );

    keypad_matrix_emulator #(.BOUNCE_TOGGLES(0), .BOUNCE_PERIOD(2), .GAP_CYCLES(8)) dut_nb (
        .clk(clk), .reset(reset), .shift_col(b_shift_col), .key_req_valid(b_valid),
        .key_req_idx(b_idx), .key_req_hold(b_hold), .key_req_ready(b_ready),
        .abort(b_abort), .row(b_row), .busy(b_busy), .done(b_done), .aborted(b_aborted),
        .contact(b_contact), .state_dbg(b_state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: one entry per future cycle, {phase[1:0], contact, aborted}
    logic [3:0] exp_q[$];
    logic [3:0] cur = {PH_IDLE, 2'b00};
    logic [3:0] m_idx = 4'd0;
    bit         chk_en = 1'b0;

    function automatic void push_press(input logic [7:0] hold);
        int h = (hold == 8'd0) ? 1 : int'(hold);
        for (int k = 0; k < BT * BP; k++) exp_q.push_back({PH_ACT, ((k / BP) % 2) == 0, 1'b0});
        for (int k = 0; k < h; k++)       exp_q.push_back({PH_ACT, 1'b1, 1'b0});
        for (int k = 0; k < BT * BP; k++) exp_q.push_back({PH_ACT, ((k / BP) % 2) == 1, 1'b0});
        for (int k = 0; k < GAP; k++)     exp_q.push_back({PH_GAP, 2'b00});
        exp_q.push_back({PH_DONE, 2'b00});
    endfunction

    function automatic void push_abort();
        exp_q.delete();
        for (int k = 0; k < GAP; k++) exp_q.push_back({PH_GAP, 2'b00});
        exp_q.push_back({PH_DONE, 2'b01});
    endfunction

    function automatic logic [3:0] model_row(input logic c, input logic [3:0] idx, input logic [3:0] sc);
        logic [3:0] r;
        r = 4'b1111;
        if (c && !sc[idx[3:2]]) r[idx[1:0]] = 1'b0;
        return r;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            cur = {PH_IDLE, 2'b00};
        end else begin
            if ((cur[3:2] == PH_IDLE || cur[3:2] == PH_DONE) && key_req_valid) begin
                m_idx = key_req_idx;
                push_press(key_req_hold);
            end else if (abort && cur[3:2] == PH_ACT) begin
                push_abort();
            end
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = {PH_IDLE, 2'b00};
        end
    end

    logic m_busy;
    always @(negedge clk) begin
        if (chk_en) begin
            m_busy = (cur[3:2] == PH_ACT) || (cur[3:2] == PH_GAP);
            chk("row", {28'd0, row}, {28'd0, model_row(cur[1], m_idx, shift_col)});
            chk("contact", {31'd0, contact}, {31'd0, cur[1]});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("ready", {31'd0, key_req_ready}, {31'd0, !m_busy});
            chk("done", {31'd0, done}, {31'd0, cur[3:2] == PH_DONE});
            if (cur[3:2] == PH_DONE) chk("aborted", {31'd0, aborted}, {31'd0, cur[0]});
        end
    end

    // driver tasks: all called and returning at 1ns after a rising edge
    task automatic send(input logic [3:0] idx, input logic [7:0] hold);
        int guard = 0;
        key_req_valid = 1'b1;
        key_req_idx   = idx;
        key_req_hold  = hold;
        while (!key_req_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("send_ready_timeout", {31'd0, guard >= 2000}, 32'd0);
        @(posedge clk); #1;
        key_req_valid = 1'b0;
        key_req_idx   = ~idx;
        key_req_hold  = 8'hA5;
    endtask

    task automatic send_b(input logic [3:0] idx, input logic [7:0] hold);
        int guard = 0;
        b_valid = 1'b1;
        b_idx   = idx;
        b_hold  = hold;
        while (!b_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("send_b_ready_timeout", {31'd0, guard >= 2000}, 32'd0);
        @(posedge clk); #1;
        b_valid = 1'b0;
        b_idx   = ~idx;
        b_hold  = 8'h5A;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_done_timeout", {31'd0, n >= 2000}, 32'd0);
    endtask

    task automatic pulse_abort(input int edges_before);
        repeat (edges_before) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    logic [3:0] col_pat [4];
    logic [26:0] seq;
    int n;
    int seen;

    initial begin
        reset = 1'b1;
        shift_col = 4'b1111; key_req_valid = 1'b0; key_req_idx = 4'd0; key_req_hold = 8'd0; abort = 1'b0;
        b_shift_col = 4'b1111; b_valid = 1'b0; b_idx = 4'd0; b_hold = 8'd0; b_abort = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_row", {28'd0, row}, 32'hF);
        chk("rst_ready", {31'd0, key_req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_aborted", {31'd0, aborted}, 32'd0);
        chk("rst_contact", {31'd0, contact}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // bounce profile with defaults, key 0, hold 3
        shift_col = 4'b1110;
        send(4'h0, 8'd3);
        chk("t3_row_k1", {28'd0, row}, 32'hE);
        for (int i = 0; i < 27; i++) begin
            seq[26 - i] = contact;
            @(posedge clk); #1;
        end
        chk("t3_contact_seq", {5'd0, seq}, {5'd0, 27'b110011001110011001100000000});
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_aborted", {31'd0, aborted}, 32'd0);

        // valid held while busy, idx changed mid-press; second accepted on the done cycle
        shift_col = 4'b0000;
        send(4'h9, 8'd4);
        key_req_valid = 1'b1;
        key_req_idx   = 4'h9;
        key_req_hold  = 8'd4;
        repeat (2) begin @(posedge clk); #1; end
        key_req_idx  = 4'h3;
        key_req_hold = 8'd2;
        n = 2;
        while (!done && n < 2000) begin @(posedge clk); #1; n++; end
        chk("t4_first_done_lat", n, 32'd28);
        @(posedge clk); #1;
        key_req_valid = 1'b0;
        chk("t4_second_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        chk("t4_second_done_lat", n, 32'd26);

        // abort on HOLD cycle 2 (hold cycles are k=9..13)
        shift_col = 4'b1011;
        send(4'hA, 8'd5);
        pulse_abort(9);
        chk("t5_contact_after_abort", {31'd0, contact}, 32'd0);
        wait_done(n);
        chk("t5_gap_len", n, 32'd8);
        chk("t5_aborted", {31'd0, aborted}, 32'd1);

        // aborted clears on next accept; hold=0 behaves as hold=1
        send(4'h7, 8'd0);
        wait_done(n);
        chk("hold0_done_lat", n, 32'd25);
        chk("hold0_aborted", {31'd0, aborted}, 32'd0);

        // abort during a press-bounce open step, on the last release cycle, in GAP and in IDLE
        shift_col = 4'b0101;
        send(4'h5, 8'd2);
        pulse_abort(2);
        wait_done(n);
        send(4'hC, 8'd2);
        pulse_abort(17);
        wait_done(n);
        chk("abort_last_rel_gap", n, 32'd8);
        send(4'hF, 8'd1);
        pulse_abort(19);
        wait_done(n);
        pulse_abort(0);
        repeat (3) begin @(posedge clk); #1; end

        // every key, with the column drive changing each cycle
        for (int i = 0; i < 16; i++) begin
            col_pat[0] = ~(4'b0001 << (i / 4));
            col_pat[1] = 4'b0000;
            col_pat[2] = ~(4'b0001 << ((i / 4 + 1) % 4));
            col_pat[3] = 4'b1111;
            shift_col = col_pat[0];
            send(i[3:0], 8'd6);
            n = 0;
            while (!done && n < 2000) begin
                shift_col = col_pat[n % 4];
                @(posedge clk); #1;
                n++;
            end
            chk("sweep_done_lat", n, 32'd30);
        end

        // reset mid-HOLD
        shift_col = 4'b1101;
        send(4'h5, 8'd20);
        repeat (11) begin @(posedge clk); #1; end
        chk("t1_row_before", {28'd0, row}, 32'hD);
        #2 reset = 1'b0;
        #1;
        chk("t1_row", {28'd0, row}, 32'hF);
        chk("t1_ready", {31'd0, key_req_ready}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("t1_no_done", seen, 32'd0);

        // no-bounce instance, key 6 hold 10
        b_shift_col = 4'b1101;
        send_b(4'h6, 8'd10);
        for (int k = 1; k <= 18; k++) begin
            chk("t2_row", {28'd0, b_row}, (k <= 10) ? 32'hB : 32'hF);
            chk("t2_no_done", {31'd0, b_done}, 32'd0);
            @(posedge clk); #1;
        end
        chk("t2_done", {31'd0, b_done}, 32'd1);
        b_shift_col = 4'b1110;
        send_b(4'h6, 8'd10);
        for (int k = 1; k <= 18; k++) begin
            chk("t2_row_other_col", {28'd0, b_row}, 32'hF);
            @(posedge clk); #1;
        end
        chk("t2_done_other_col", {31'd0, b_done}, 32'd1);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
